// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider arbiter
package div_pkg;

    localparam int DIV_BIT_SIZE = 16;

    // Every quotient bit of a divide-by-zero answer takes this value.
    localparam logic DIV_DBZ_QUOTIENT_BIT = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        RESP = 3'b100
    } div_state_t;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - iterative restoring unsigned divider, one quotient bit per cycle
module div_core
    import div_pkg::*;
#(
    parameter int BIT_SIZE = DIV_BIT_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIT_SIZE-1:0] dividend,
    input  logic [BIT_SIZE-1:0] divisor,
    output logic                done,
    output logic [BIT_SIZE-1:0] quotient,
    output logic [BIT_SIZE-1:0] remainder
);

    localparam int CNT_W = $clog2(BIT_SIZE + 1);

    logic [BIT_SIZE:0]   acc_q, acc_d;
    logic [BIT_SIZE-1:0] quo_q, quo_d;
    logic [BIT_SIZE-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    logic [BIT_SIZE:0]   step_acc;
    logic [BIT_SIZE-1:0] step_quo;
    logic [BIT_SIZE-1:0] step_dvs;
    logic [BIT_SIZE:0]   shifted;
    logic [BIT_SIZE:0]   trial;

    // One restoring step; the start cycle already runs the first step on the fresh operands.
    always_comb begin
        step_acc = start ? '0 : acc_q;
        step_quo = start ? dividend : quo_q;
        step_dvs = start ? divisor : dvs_q;
        shifted  = (step_acc << 1) | {{BIT_SIZE{1'b0}}, step_quo[BIT_SIZE-1]};
        trial    = shifted - {1'b0, step_dvs};
    end

    // Iterate while steps remain; done pulses once the last quotient bit is registered.
    always_comb begin
        acc_d  = acc_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start || (cnt_q != '0)) begin
            acc_d  = trial[BIT_SIZE] ? shifted : trial;
            quo_d  = (step_quo << 1) | {{(BIT_SIZE-1){1'b0}}, ~trial[BIT_SIZE]};
            dvs_d  = step_dvs;
            cnt_d  = start ? CNT_W'(BIT_SIZE - 1) : cnt_q - CNT_W'(1);
            done_d = (cnt_d == '0);
        end
    end

    // Datapath registers, cleared by reset so an aborted divide leaves nothing behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = acc_q[BIT_SIZE-1:0];

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one restoring divider between requesters
module div_arbiter
    import div_pkg::*;
#(
    parameter int BIT_SIZE = DIV_BIT_SIZE,
    parameter int NUM_REQ  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BIT_SIZE-1:0]  req_dividend,
    input  logic [NUM_REQ*BIT_SIZE-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [BIT_SIZE-1:0]          rsp_quotient,
    output logic [BIT_SIZE-1:0]          rsp_remainder,
    output logic                         rsp_dbz,
    output logic                         busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    div_state_t          state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [BIT_SIZE-1:0] quo_q, quo_d;
    logic [BIT_SIZE-1:0] rem_q, rem_d;
    logic                dbz_q, dbz_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    scan_idx;
    logic                found;
    logic                accept;
    logic [BIT_SIZE-1:0] sel_dividend;
    logic [BIT_SIZE-1:0] sel_divisor;
    logic                core_start;
    logic                core_done;
    logic [BIT_SIZE-1:0] core_quotient;
    logic [BIT_SIZE-1:0] core_remainder;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[IDX_W-1:0];
    endfunction

    // Pick the first valid requester after the last one served, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = wrap_idx(last_grant_q, k);
            if (!found && req_valid[scan_idx]) begin
                found            = 1'b1;
                grant[scan_idx]  = 1'b1;
                grant_idx        = scan_idx;
            end
        end
    end

    assign req_ready    = (state_q == IDLE) ? grant : '0;
    assign accept       = |req_ready;
    assign sel_dividend = req_dividend[grant_idx*BIT_SIZE +: BIT_SIZE];
    assign sel_divisor  = req_divisor[grant_idx*BIT_SIZE +: BIT_SIZE];

    // Sequencer: accept, run the core or answer divide-by-zero directly, then hold the response.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        rsp_valid_d  = rsp_valid_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dbz_d        = dbz_q;
        core_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant_idx;
                    idx_d        = grant_idx;
                    if (sel_divisor == '0) begin
                        state_d     = RESP;
                        quo_d       = {BIT_SIZE{DIV_DBZ_QUOTIENT_BIT}};
                        rem_d       = sel_dividend;
                        dbz_d       = 1'b1;
                        rsp_valid_d = grant;
                    end else begin
                        state_d    = RUN;
                        core_start = 1'b1;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d            = RESP;
                    quo_d              = core_quotient;
                    rem_d              = core_remainder;
                    dbz_d              = 1'b0;
                    rsp_valid_d        = '0;
                    rsp_valid_d[idx_q] = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready[idx_q]) begin
                    state_d     = IDLE;
                    rsp_valid_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = '0;
            end
        endcase
    end

    // State, pointer and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            idx_q        <= '0;
            rsp_valid_q  <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            rsp_valid_q  <= rsp_valid_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dbz_q        <= dbz_d;
        end
    end

    div_core #(
        .BIT_SIZE (BIT_SIZE)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .dividend  (sel_dividend),
        .divisor   (sel_divisor),
        .done      (core_done),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_dbz       = dbz_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter
module tb_div_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_dividend;
    logic [N*W-1:0]  req_divisor;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [W-1:0]    rsp_quotient;
    logic [W-1:0]    rsp_remainder;
    logic            rsp_dbz;
    logic            busy;

    logic [W-1:0]    op_a [N];
    logic [W-1:0]    op_b [N];
    int              checks = 0;
    int              errors = 0;
    int              last_grant;
    int              cyc = 0;

    div_arbiter #(.BIT_SIZE(W), .NUM_REQ(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = op_a[i];
            req_divisor[i*W +: W]  = op_b[i];
        end
    endtask

    task automatic check_rsp(input string tag, input int w, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q_exp, r_exp;
        logic         dbz_exp;
        if (b == 0) begin
            q_exp = '1; r_exp = a; dbz_exp = 1'b1;
        end else begin
            q_exp = a / b; r_exp = a % b; dbz_exp = 1'b0;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 32'(1) << w);
        chk({tag, "_quotient"}, rsp_quotient, q_exp);
        chk({tag, "_remainder"}, rsp_remainder, r_exp);
        chk({tag, "_dbz"}, rsp_dbz, dbz_exp);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid == '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_grant = N - 1;
    endtask

    task automatic rand_ops(input int i, input bit allow_zero);
        op_a[i] = W'($urandom);
        if (allow_zero && $urandom_range(0, 5) == 0) op_b[i] = '0;
        else if ($urandom_range(0, 1) == 0)          op_b[i] = W'($urandom_range(1, 300));
        else                                          op_b[i] = W'($urandom_range(1, 65535));
    endtask

    // One transaction with rsp_ready held high: grant check, latency, result, return to idle.
    task automatic xact(input string tag, input logic [N-1:0] mask);
        int w, lat;
        @(negedge clk);
        drive_ops();
        req_valid = mask;
        #1;
        w = rr_winner(mask, last_grant);
        chk({tag, "_grant"}, req_ready, 32'(1) << w);
        @(negedge clk);
        req_valid = '0;
        last_grant = w;
        wait_rsp(lat);
        chk({tag, "_latency"}, lat, (op_b[w] == 0) ? 0 : W);
        check_rsp(tag, w, op_a[w], op_b[w]);
        @(negedge clk);
        chk({tag, "_idle"}, {rsp_valid, busy}, 0);
    endtask

    initial begin
        int w, lat, acc, prev_acc, bad;
        logic [W-1:0] ea, eb;

        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        drive_ops();
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_quotient", rsp_quotient, 0);
        chk("reset_remainder", rsp_remainder, 0);
        chk("reset_dbz_busy", {rsp_dbz, busy}, 0);
        reset = 1'b0;
        last_grant = N - 1;

        // 100 / 7 from requester 0
        op_a[0] = 16'd100; op_b[0] = 16'd7;
        xact("basic", 4'b0001);

        // All requesters continuously valid: rotation order and issue spacing
        do_reset();
        for (int i = 0; i < N; i++) rand_ops(i, 1'b0);
        drive_ops();
        req_valid = '1;
        rsp_ready = '1;
        #1;
        prev_acc = 0;
        for (int n = 0; n < 5; n++) begin
            w = rr_winner('1, last_grant);
            chk("rr_grant", req_ready, 32'(1) << w);
            @(negedge clk);
            acc = cyc;
            ea = op_a[w]; eb = op_b[w];
            rand_ops(w, 1'b0);
            drive_ops();
            last_grant = w;
            if (n > 0) chk("rr_spacing", acc - prev_acc, W + 2);
            prev_acc = acc;
            wait_rsp(lat);
            chk("rr_latency", lat, W);
            check_rsp("rr", w, ea, eb);
            if (n == 4) req_valid = '0;
            @(negedge clk);
            #1;
        end
        chk("rr_idle", {rsp_valid, busy}, 0);

        // Divide by zero from requester 2
        op_a[2] = 16'h1234; op_b[2] = 16'h0000;
        xact("dbz", 4'b0100);

        // Response back-pressure: 0xFFFF / 1 held for 10 cycles
        @(negedge clk);
        for (int i = 0; i < N; i++) rand_ops(i, 1'b0);
        op_a[1] = 16'hFFFF; op_b[1] = 16'h0001;
        drive_ops();
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        #1;
        w = rr_winner(4'b0010, last_grant);
        chk("hold_grant", req_ready, 32'(1) << w);
        @(negedge clk);
        req_valid = 4'b1101;
        last_grant = w;
        wait_rsp(lat);
        chk("hold_latency", lat, W);
        check_rsp("hold", 1, 16'hFFFF, 16'h0001);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rsp_ready = W'($urandom) & 4'b1101;
            if (rsp_quotient !== 16'hFFFF || rsp_remainder !== 16'h0000 || rsp_valid !== 4'b0010
                || req_ready !== 4'b0000 || busy !== 1'b1 || rsp_dbz !== 1'b0)
                bad++;
        end
        chk("hold_stable_cycles", bad, 0);
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clk);
        chk("hold_release", {rsp_valid, busy}, 0);

        // Reset during RUN aborts, then round-robin pointer restarts at 0
        @(negedge clk);
        rand_ops(1, 1'b0);
        drive_ops();
        req_valid = 4'b0010;
        #1;
        w = rr_winner(4'b0010, last_grant);
        chk("abort_grant", req_ready, 32'(1) << w);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_outputs", {rsp_quotient, rsp_remainder}, 0);
        chk("abort_flags", {req_ready, rsp_dbz, busy}, 0);
        reset = 1'b0;
        last_grant = N - 1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) bad++;
        end
        chk("abort_no_rsp", bad, 0);
        op_a[0] = 16'd9; op_b[0] = 16'd3;
        rand_ops(2, 1'b0);
        xact("after_abort", 4'b0101);

        // Edge operands
        op_a[1] = 16'd5; op_b[1] = 16'd9;
        xact("small_over_big", 4'b0010);
        op_a[3] = 16'd0; op_b[3] = 16'd5;
        xact("zero_dividend", 4'b1000);

        // Random masks and operands against the model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) rand_ops(i, 1'b1);
            xact("random", N'($urandom_range(1, (1 << N) - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
